// File: rtl/imem_program_loader.sv
// Boot-time instruction memory loader: assembles a little-endian byte stream into 32-bit words
// and writes them through address_pointer/BUS/we. Optional trailing checksum: LOADER_CHECKSUM_EN.
module imem_program_loader #(
  parameter int MEM_DEPTH = 151,
  parameter int CNT_W     = 16
) (
  input  logic        clk_input,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic [31:0] address_pointer,
  inout  wire  [31:0] BUS,
  output logic        prg_mode,
  output logic        we,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    HDR0      = 4'd1,
    HDR1      = 4'd2,
    CHECK_CNT = 4'd3,
    DATA      = 4'd4,
    WRITE     = 4'd5,
    FIN       = 4'd6,
    CHK       = 4'd7,
    DONE      = 4'd8,
    ERR       = 4'd9
  } state_t;

  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(MEM_DEPTH);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] word_cnt, word_cnt_n, word_cnt_inc;
  logic [1:0]       byte_idx, byte_idx_n;
  logic [31:0]      word, word_n, addr_n;
  logic             take, load_start;
  logic             byte_ready_n, prg_mode_n, we_n, busy_n, done_n, error_n;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum, csum_n;

  function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`endif

  // The memory samples BUS while we is high; nothing is driven in run mode.
  assign BUS = we ? word : {32{1'bz}};

  // Next-state and next-output logic; outputs are registered from the next state.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    word_cnt_n   = word_cnt;
    byte_idx_n   = byte_idx;
    word_n       = word;
    addr_n       = address_pointer;
    load_start   = 1'b0;
    take         = byte_valid & byte_ready;
    word_cnt_inc = word_cnt + CNT_W'(1);

    case (state)
      IDLE, ERR: begin
        if (start) begin
          load_start = 1'b1;
          cnt_n      = {CNT_W{1'b0}};
          word_cnt_n = {CNT_W{1'b0}};
          byte_idx_n = 2'd0;
          addr_n     = 32'd0;
          state_n    = HDR0;
        end else begin
          state_n = state;
        end
      end
      HDR0: begin
        if (take) begin
          cnt_n[7:0] = byte_data;
          state_n    = HDR1;
        end else begin
          state_n = HDR0;
        end
      end
      HDR1: begin
        if (take) begin
          cnt_n[15:8] = byte_data;
          state_n     = CHECK_CNT;
        end else begin
          state_n = HDR1;
        end
      end
      CHECK_CNT: begin
        if (cnt > DEPTH) begin
          state_n = ERR;
        end else if (cnt == {CNT_W{1'b0}}) begin
          state_n = FIN;
        end else begin
          state_n = DATA;
        end
      end
      DATA: begin
        if (take) begin
          word_n     = {byte_data, word[31:8]};
          byte_idx_n = byte_idx + 2'd1;
          state_n    = (byte_idx == 2'd3) ? WRITE : DATA;
        end else begin
          state_n = DATA;
        end
      end
      WRITE: begin
        word_cnt_n = word_cnt_inc;
        byte_idx_n = 2'd0;
        // Pointer stops at the last written word so it never exceeds MEM_DEPTH-1.
        if (word_cnt_inc == cnt) begin
          state_n = FIN;
        end else begin
          addr_n  = address_pointer + 32'd1;
          state_n = DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      FIN: state_n = CHK;
      CHK: begin
        if (take) begin
          state_n = (byte_data == csum) ? DONE : ERR;
        end else begin
          state_n = CHK;
        end
      end
`else
      FIN: state_n = DONE;
`endif
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

`ifdef LOADER_CHECKSUM_EN
    if (load_start) begin
      csum_n = 8'h00;
    end else if (take && (state != CHK)) begin
      csum_n = csum_fold(csum, byte_data);
    end else begin
      csum_n = csum;
    end
`endif

    byte_ready_n = state_n inside {HDR0, HDR1, DATA, CHK};
    busy_n       = !(state_n inside {IDLE, DONE, ERR});
    prg_mode_n   = state_n inside {IDLE, DONE};
    we_n         = (state_n == WRITE);
    done_n       = (state_n == DONE);
    error_n      = (state_n == ERR);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk_input or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= {CNT_W{1'b0}};
      word_cnt        <= {CNT_W{1'b0}};
      byte_idx        <= 2'd0;
      word            <= 32'd0;
      address_pointer <= 32'd0;
      byte_ready      <= 1'b0;
      prg_mode        <= 1'b1;
      we              <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum            <= 8'h00;
`endif
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      word_cnt        <= word_cnt_n;
      byte_idx        <= byte_idx_n;
      word            <= word_n;
      address_pointer <= addr_n;
      byte_ready      <= byte_ready_n;
      prg_mode        <= prg_mode_n;
      we              <= we_n;
      busy            <= busy_n;
      done            <= done_n;
      error           <= error_n;
`ifdef LOADER_CHECKSUM_EN
      csum            <= csum_n;
`endif
    end
  end

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader with a behavioural instruction memory on BUS.
// Honours LOADER_CHECKSUM_EN by appending the XOR checksum byte to each stream.
module tb_imem_program_loader;

  localparam logic [31:0] RDATA = 32'hA5A5_5A5A;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic [31:0] address_pointer;
  wire  [31:0] bus_w;
  logic        prg_mode;
  logic        we;
  logic        busy;
  logic        done;
  logic        error;

  int          vectors = 0;
  int          miscompares = 0;
  int          we_count = 0;
  int          done_count = 0;
  int          proto_err = 0;
  logic [31:0] tb_mem [0:255];
  logic [31:0] words  [0:150];
  logic [7:0]  csum_acc;

  imem_program_loader dut (
    .clk_input      (clk),
    .rst            (rst),
    .start          (start),
    .byte_valid     (byte_valid),
    .byte_data      (byte_data),
    .byte_ready     (byte_ready),
    .address_pointer(address_pointer),
    .BUS            (bus_w),
    .prg_mode       (prg_mode),
    .we             (we),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  always #5 clk = ~clk;

  // Memory read data appears on the bus in run mode, as instruction_mem would drive it.
  assign bus_w = prg_mode ? RDATA : {32{1'bz}};

  // Memory model and protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      we_count <= we_count + 1;
      tb_mem[address_pointer[7:0]] <= bus_w;
      if (prg_mode !== 1'b0 || byte_ready !== 1'b0 || address_pointer[31:8] !== 24'd0)
        proto_err <= proto_err + 1;
    end
    if (done === 1'b1) done_count <= done_count + 1;
    if (prg_mode === 1'b1 && bus_w !== RDATA) proto_err <= proto_err + 1;
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (byte_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    if (ok) begin
      csum_acc = csum_acc ^ b;
    end else begin
      vectors++;
      miscompares++;
      $display("FAIL byte_accept: byte %h not accepted within 100 cycles, want byte_ready=1", b);
    end
  endtask

  task automatic send_header(input logic [15:0] c);
    csum_acc = 8'h00;
    send_byte(c[7:0]);
    send_byte(c[15:8]);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    int g;
    for (int b = 0; b < 4; b++) begin
      g = gaps ? $urandom_range(0, 2) : 0;
      if (g > 0) begin
        byte_valid = 1'b0;
        repeat (g) @(posedge clk);
        #1;
      end
      send_byte(w[8*b +: 8]);
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic send_checksum(input logic [7:0] flip);
    logic [7:0] c;
    c = csum_acc ^ flip;
    send_byte(c);
    byte_valid = 1'b0;
  endtask
`endif

  task automatic wait_done(input int limit, output int cycles);
    cycles = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cycles = i;
        break;
      end
    end
    vectors++;
    if (cycles < 0) begin
      miscompares++;
      $display("FAIL done_wait: no done pulse within %0d cycles, want one", limit);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    vectors++; if (prg_mode !== 1'b1) begin miscompares++; $display("FAIL reset_prg_mode: got %b want 1", prg_mode); end
    vectors++; if (we !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b want 0", we); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL reset_error: got %b want 0", error); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++; if (byte_ready !== 1'b0) begin miscompares++; $display("FAIL reset_byte_ready: got %b want 0", byte_ready); end
    vectors++; if (address_pointer !== 32'd0) begin miscompares++; $display("FAIL reset_addr: got %h want 0", address_pointer); end
    vectors++; if (bus_w !== RDATA) begin miscompares++; $display("FAIL reset_bus_released: got %h want %h", bus_w, RDATA); end
  endtask

  task automatic test_two_words();
    int we0, done0, cyc;
    we0 = we_count; done0 = done_count;
    pulse_start();
    vectors++; if (busy !== 1'b1 || prg_mode !== 1'b0) begin miscompares++; $display("FAIL start_busy_prg: got busy=%b prg=%b want 1/0", busy, prg_mode); end
    send_header(16'h0002);
    send_word(32'h12345678, 1'b0);
    vectors++; if (we !== 1'b1 || byte_ready !== 1'b0) begin miscompares++; $display("FAIL write_cycle: got we=%b ready=%b want 1/0", we, byte_ready); end
    vectors++; if (address_pointer !== 32'd0 || bus_w !== 32'h12345678) begin miscompares++; $display("FAIL write_addr_bus: got %h/%h want 0/12345678", address_pointer, bus_w); end
    @(posedge clk); #1;
    vectors++; if (we !== 1'b0 || byte_ready !== 1'b1 || address_pointer !== 32'd1) begin miscompares++; $display("FAIL after_write: got we=%b ready=%b addr=%h want 0/1/1", we, byte_ready, address_pointer); end
    send_word(32'hDEADBEEF, 1'b0);
    byte_valid = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    send_checksum(8'h00);
`endif
    wait_done(10, cyc);
    vectors++; if (prg_mode !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin miscompares++; $display("FAIL done_state: got prg=%b busy=%b err=%b want 1/0/0", prg_mode, busy, error); end
    @(posedge clk); #1;
    vectors++; if (we_count - we0 !== 2) begin miscompares++; $display("FAIL two_we_pulses: got %0d want 2", we_count - we0); end
    vectors++; if (done_count - done0 !== 1) begin miscompares++; $display("FAIL two_done_pulses: got %0d want 1", done_count - done0); end
    vectors++; if (tb_mem[0] !== 32'h12345678) begin miscompares++; $display("FAIL mem0: got %h want 12345678", tb_mem[0]); end
    vectors++; if (tb_mem[1] !== 32'hDEADBEEF) begin miscompares++; $display("FAIL mem1: got %h want deadbeef", tb_mem[1]); end
    byte_valid = 1'b1; byte_data = 8'h77;
    repeat (3) @(negedge clk);
    vectors++; if (byte_ready !== 1'b0) begin miscompares++; $display("FAIL idle_not_ready: got %b want 0", byte_ready); end
    byte_valid = 1'b0;
  endtask

  task automatic test_overflow();
    int we0, cyc;
    we0 = we_count;
    pulse_start();
    send_header(16'h0098);
    byte_valid = 1'b1; byte_data = 8'h11;
    repeat (2) @(posedge clk); #1;
    vectors++; if (error !== 1'b1 || prg_mode !== 1'b0) begin miscompares++; $display("FAIL ovf_err: got err=%b prg=%b want 1/0", error, prg_mode); end
    vectors++; if (busy !== 1'b0 || byte_ready !== 1'b0) begin miscompares++; $display("FAIL ovf_idle: got busy=%b ready=%b want 0/0", busy, byte_ready); end
    vectors++; if (we_count - we0 !== 0) begin miscompares++; $display("FAIL ovf_no_we: got %0d want 0", we_count - we0); end
    byte_valid = 1'b0;
    pulse_start();
    vectors++; if (error !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL ovf_restart: got err=%b busy=%b want 0/1", error, busy); end
    send_header(16'h0000);
    byte_valid = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    send_checksum(8'h00);
`endif
    wait_done(10, cyc);
    @(posedge clk); #1;
  endtask

  task automatic test_zero_count();
    int we0, done0, cyc;
    we0 = we_count; done0 = done_count;
    pulse_start();
    send_header(16'h0000);
    byte_valid = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    send_checksum(8'h00);
`endif
    wait_done(4, cyc);
    @(posedge clk); #1;
    vectors++; if (we_count - we0 !== 0 || done_count - done0 !== 1) begin miscompares++; $display("FAIL zero_cnt: got we=%0d done=%0d want 0/1", we_count - we0, done_count - done0); end
    vectors++; if (prg_mode !== 1'b1) begin miscompares++; $display("FAIL zero_prg: got %b want 1", prg_mode); end
  endtask

  task automatic test_full_load();
    int we0, done0, perr0, cyc;
    we0 = we_count; done0 = done_count; perr0 = proto_err;
    for (int i = 0; i < 151; i++) words[i] = {8'(i) ^ 8'h5A, 8'(i * 7), ~8'(i), 8'(i)};
    pulse_start();
    send_header(16'd151);
    for (int w = 0; w < 151; w++) begin
      if (w == 40 || w == 100) pulse_start();
      send_word(words[w], (w % 3) != 0);
    end
    byte_valid = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    send_checksum(8'h00);
`endif
    wait_done(20, cyc);
    @(posedge clk); #1;
    vectors++; if (we_count - we0 !== 151) begin miscompares++; $display("FAIL full_we_count: got %0d want 151", we_count - we0); end
    vectors++; if (done_count - done0 !== 1) begin miscompares++; $display("FAIL full_done_count: got %0d want 1", done_count - done0); end
    vectors++; if (proto_err - perr0 !== 0) begin miscompares++; $display("FAIL full_protocol: got %0d violations want 0", proto_err - perr0); end
    vectors++; if (error !== 1'b0 || prg_mode !== 1'b1) begin miscompares++; $display("FAIL full_end: got err=%b prg=%b want 0/1", error, prg_mode); end
    for (int i = 0; i < 151; i++) begin
      vectors++;
      if (tb_mem[i] !== words[i]) begin
        miscompares++;
        $display("FAIL full_mem[%0d]: got %h want %h", i, tb_mem[i], words[i]);
      end
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_bad_checksum();
    int done0;
    done0 = done_count;
    pulse_start();
    send_header(16'h0002);
    send_word(32'h12345678, 1'b0);
    send_word(32'hDEADBEEF, 1'b0);
    byte_valid = 1'b0;
    send_checksum(8'h01);
    @(posedge clk); #1;
    vectors++; if (error !== 1'b1 || done_count - done0 !== 0) begin miscompares++; $display("FAIL bad_checksum: got err=%b done=%0d want 1/0", error, done_count - done0); end
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; csum_acc = 8'h00;
    test_reset();
    test_two_words();
    test_overflow();
    test_zero_count();
    test_full_load();
    vectors++; if (proto_err !== 0) begin miscompares++; $display("FAIL bus_protocol: got %0d violations want 0", proto_err); end
`ifdef LOADER_CHECKSUM_EN
    test_bad_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
